// File: rtl/eth_idma_pkg.sv
// ============================================================================
// Module  : eth_idma_pkg
// Brief   : Shared types for the Ethernet RX frame buffer feeding the iDMA.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_idma_pkg;

    typedef logic [15:0] frame_len_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DROP = 2'd2
    } rx_fsm_e;

endpackage

`default_nettype wire

// File: rtl/fifo_v3.sv
// ============================================================================
// Module  : fifo_v3
// Brief   : Port-compatible FIFO with the common_cells fifo_v3 interface.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned FIFO_DEPTH = (DEPTH > 0) ? DEPTH : 1;
    localparam int unsigned CNT_W      = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [CNT_W-1:0]      r_status_cnt;
    dtype                  r_mem [FIFO_DEPTH];

    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_unused_testmode;

    assign w_unused_testmode = testmode_i;

    assign usage_o  = r_status_cnt[ADDR_DEPTH-1:0];
    assign full_o   = (r_status_cnt == CNT_W'(FIFO_DEPTH));
    assign empty_o  = (r_status_cnt == '0) && !(FALL_THROUGH && push_i);
    assign w_push   = push_i && !full_o;
    assign w_pop    = pop_i && !empty_o;
    // Fall-through with an empty store: the word passes straight through.
    assign w_bypass = FALL_THROUGH && (r_status_cnt == '0) && push_i && pop_i;
    assign data_o   = (FALL_THROUGH && (r_status_cnt == '0)) ? data_i : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_status_cnt <= '0;
        end else if (flush_i) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_status_cnt <= '0;
        end else if (!w_bypass) begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == ADDR_DEPTH'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_DEPTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == ADDR_DEPTH'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + ADDR_DEPTH'(1);
            end
            if (w_push && !w_pop) begin
                r_status_cnt <= r_status_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_status_cnt <= r_status_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !w_bypass && !flush_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/eth_rx_frame_buf.sv
// ============================================================================
// Module  : eth_rx_frame_buf
// Brief   : Store-and-forward RX frame buffer between MAC and iDMA stream.
//           Optional counters enabled by macro ETH_RX_BUF_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_rx_frame_buf #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned DepthBeats = 512,
    parameter int unsigned MaxFrames  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DataWidth-1:0]   s_tdata_i,
    input  logic [DataWidth/8-1:0] s_tkeep_i,
    input  logic                   s_tlast_i,
    input  logic                   s_tuser_i,
    input  logic                   s_tvalid_i,
    output logic                   s_tready_o,
    output logic [DataWidth-1:0]   m_tdata_o,
    output logic [DataWidth/8-1:0] m_tkeep_o,
    output logic                   m_tlast_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic [15:0]            frame_len_o,
    output logic                   frame_avail_o,
    output logic [15:0]            frames_rx_o,
    output logic [15:0]            frames_drop_o
);

    import eth_idma_pkg::*;

    localparam int unsigned KEEP_W = DataWidth / 8;
    localparam int unsigned ADDR_W = (DepthBeats > 1) ? $clog2(DepthBeats) : 1;
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned MEM_W  = DataWidth + KEEP_W + 1;
    localparam int unsigned LEN_AW = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

    rx_fsm_e          r_state;
    rx_fsm_e          w_state_nxt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_commit_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [16:0]      r_byte_cnt;
    logic [MEM_W-1:0] r_mem [DepthBeats];

    logic [DataWidth-1:0] r_m_tdata;
    logic [KEEP_W-1:0]    r_m_tkeep;
    logic                 r_m_tlast;
    logic                 r_m_tvalid;

    logic              w_beat;
    logic              w_full;
    logic              w_wr_en;
    logic              w_commit;
    logic              w_drop_frame;
    logic [16:0]       w_popcnt;
    logic [16:0]       w_len_sum;
    logic              w_len_big;
    logic              w_len_full;
    logic              w_len_empty;
    logic              w_len_pop;
    frame_len_t        w_len_in;
    frame_len_t        w_len_out;
    logic [LEN_AW-1:0] w_unused_len_usage;
    logic              w_rd_avail;
    logic              w_load;

    // The MAC cannot be stalled; only reset withdraws ready.
    assign s_tready_o = ~rst_i;
    assign w_beat     = s_tvalid_i & s_tready_o;
    assign w_full     = ((r_wr_ptr - r_rd_ptr) == PTR_W'(DepthBeats));

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_popcnt = w_popcnt + 17'(s_tkeep_i[i]);
        end
    end

    assign w_len_sum = {1'b0, r_byte_cnt[15:0]} + w_popcnt;
    assign w_len_big = r_byte_cnt[16] | w_len_sum[16];
    assign w_len_in  = w_len_sum[15:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_drop_frame = 1'b0;
        if (w_beat) begin
            unique case (r_state)
                RX_DROP: begin
                    if (s_tlast_i) begin
                        w_state_nxt = RX_IDLE;
                    end
                end
                default: begin
                    if (w_full) begin
                        w_drop_frame = 1'b1;
                        w_state_nxt  = s_tlast_i ? RX_IDLE : RX_DROP;
                    end else begin
                        w_wr_en = 1'b1;
                        if (s_tlast_i) begin
                            w_state_nxt = RX_IDLE;
                            if (s_tuser_i || w_len_full || w_len_big) begin
                                w_drop_frame = 1'b1;
                            end else begin
                                w_commit = 1'b1;
                            end
                        end else begin
                            w_state_nxt = RX_RECV;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= RX_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_byte_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_drop_frame) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_beat) begin
                r_byte_cnt <= s_tlast_i ? '0 : {w_len_big, w_len_sum[15:0]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_tlast_i, s_tkeep_i, s_tdata_i};
        end
    end

    // Only committed beats are visible to the read side.
    assign w_rd_avail = (r_rd_ptr != r_commit_ptr);
    assign w_load     = w_rd_avail && (!r_m_tvalid || m_tready_i);
    assign w_len_pop  = r_m_tvalid && m_tready_i && r_m_tlast;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr   <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_load) begin
            {r_m_tlast, r_m_tkeep, r_m_tdata} <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            r_m_tvalid <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        end else if (m_tready_i) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tdata_o  = r_m_tdata;
    assign m_tkeep_o  = r_m_tkeep;
    assign m_tlast_o  = r_m_tlast;
    assign m_tvalid_o = r_m_tvalid;

    // Synchronous reset enters through flush; the async reset stays inactive.
    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(frame_len_t)),
        .DEPTH        (MaxFrames)
    ) u_len_fifo (
        .clk_i      (clk_i),
        .rst_ni     (1'b1),
        .flush_i    (rst_i),
        .testmode_i (1'b0),
        .full_o     (w_len_full),
        .empty_o    (w_len_empty),
        .usage_o    (w_unused_len_usage),
        .data_i     (w_len_in),
        .push_i     (w_commit),
        .data_o     (w_len_out),
        .pop_i      (w_len_pop)
    );

    assign frame_avail_o = ~w_len_empty;
    assign frame_len_o   = w_len_empty ? '0 : w_len_out;

`ifdef ETH_RX_BUF_STATS_EN
    logic [15:0] r_frames_rx;
    logic [15:0] r_frames_drop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frames_rx   <= '0;
            r_frames_drop <= '0;
        end else begin
            if (w_commit && (r_frames_rx != 16'hFFFF)) begin
                r_frames_rx <= r_frames_rx + 16'd1;
            end
            if (w_drop_frame && (r_frames_drop != 16'hFFFF)) begin
                r_frames_drop <= r_frames_drop + 16'd1;
            end
        end
    end

    assign frames_rx_o   = r_frames_rx;
    assign frames_drop_o = r_frames_drop;
`else
    assign frames_rx_o   = '0;
    assign frames_drop_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_frame_buf.sv
// ============================================================================
// Module  : tb_eth_rx_frame_buf
// Brief   : Self-checking bench for eth_rx_frame_buf (small buffer build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_eth_rx_frame_buf;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 8;
    localparam int MAXF  = 2;
`ifdef ETH_RX_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] s_tdata_i;
    logic [KW-1:0] s_tkeep_i;
    logic          s_tlast_i;
    logic          s_tuser_i;
    logic          s_tvalid_i;
    logic          s_tready_o;
    logic [DW-1:0] m_tdata_o;
    logic [KW-1:0] m_tkeep_o;
    logic          m_tlast_o;
    logic          m_tvalid_o;
    logic          m_tready_i;
    logic [15:0]   frame_len_o;
    logic          frame_avail_o;
    logic [15:0]   frames_rx_o;
    logic [15:0]   frames_drop_o;

    int          n_checks = 0;
    int          n_errors = 0;
    beat_t       exp_q[$];
    logic [15:0] len_q[$];
    int          exp_rx = 0;
    int          exp_drop = 0;
    bit          mon_first = 1'b1;
    bit          prev_stall = 1'b0;
    beat_t       prev_beat;
    beat_t       mon_exp;

    always #5 clk = ~clk;

    eth_rx_frame_buf #(
        .DataWidth  (DW),
        .DepthBeats (DEPTH),
        .MaxFrames  (MAXF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .s_tdata_i     (s_tdata_i),
        .s_tkeep_i     (s_tkeep_i),
        .s_tlast_i     (s_tlast_i),
        .s_tuser_i     (s_tuser_i),
        .s_tvalid_i    (s_tvalid_i),
        .s_tready_o    (s_tready_o),
        .m_tdata_o     (m_tdata_o),
        .m_tkeep_o     (m_tkeep_o),
        .m_tlast_o     (m_tlast_o),
        .m_tvalid_o    (m_tvalid_o),
        .m_tready_i    (m_tready_i),
        .frame_len_o   (frame_len_o),
        .frame_avail_o (frame_avail_o),
        .frames_rx_o   (frames_rx_o),
        .frames_drop_o (frames_drop_o)
    );

    // Output scoreboard: order, content, head length and stall stability.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
            mon_first  = 1'b1;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!m_tvalid_o || ({m_tlast_o, m_tkeep_o, m_tdata_o} !== prev_beat)) begin
                    n_errors++;
                    $display("FAIL stall_stable: got v=%b beat=%h required v=1 beat=%h",
                             m_tvalid_o, {m_tlast_o, m_tkeep_o, m_tdata_o}, prev_beat);
                end
            end
            if (m_tvalid_o && m_tready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_beat: got %h required no beat",
                             {m_tlast_o, m_tkeep_o, m_tdata_o});
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({m_tlast_o, m_tkeep_o, m_tdata_o} !== mon_exp) begin
                        n_errors++;
                        $display("FAIL out_beat: got %h required %h",
                                 {m_tlast_o, m_tkeep_o, m_tdata_o}, mon_exp);
                    end
                    if (mon_first && len_q.size() > 0) begin
                        n_checks++;
                        if (!frame_avail_o || frame_len_o !== len_q[0]) begin
                            n_errors++;
                            $display("FAIL head_len: got avail=%b len=%0d required avail=1 len=%0d",
                                     frame_avail_o, frame_len_o, len_q[0]);
                        end
                    end
                    if (mon_exp.last && len_q.size() > 0) begin
                        void'(len_q.pop_front());
                    end
                end
                mon_first = m_tlast_o;
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_beat  = {m_tlast_o, m_tkeep_o, m_tdata_o};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input int nbeats, input logic [KW-1:0] last_keep,
                              input bit bad, input bit expect_good, input int gap_pct);
        beat_t b;
        int    len;
        len = KW * (nbeats - 1) + $countones(last_keep);
        for (int i = 0; i < nbeats; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_tvalid_i = 1'b0;
                @(posedge clk); #1;
            end
            b.data = $urandom;
            b.keep = (i == nbeats - 1) ? last_keep : {KW{1'b1}};
            b.last = (i == nbeats - 1);
            s_tdata_i  = b.data;
            s_tkeep_i  = b.keep;
            s_tlast_i  = b.last;
            s_tuser_i  = b.last & bad;
            s_tvalid_i = 1'b1;
            n_checks++;
            if (s_tready_o !== 1'b1) begin
                n_errors++;
                $display("FAIL s_tready: got %b required 1", s_tready_o);
            end
            if (expect_good) exp_q.push_back(b);
            if (b.last) begin
                if (expect_good) begin
                    len_q.push_back(16'(len));
                    exp_rx++;
                end else begin
                    exp_drop++;
                end
            end
            @(posedge clk); #1;
        end
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_tuser_i  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: got %0d beats pending required 0", name, exp_q.size());
            exp_q.delete();
            len_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_counters(input string name);
        n_checks++;
        if (frames_rx_o !== (STATS ? 16'(exp_rx) : 16'd0) ||
            frames_drop_o !== (STATS ? 16'(exp_drop) : 16'd0)) begin
            n_errors++;
            $display("FAIL %s_counters: got rx=%0d drop=%0d required rx=%0d drop=%0d", name,
                     frames_rx_o, frames_drop_o, STATS ? exp_rx : 0, STATS ? exp_drop : 0);
        end
    endtask

    task automatic check_idle_out(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            n_checks++;
            if (m_tvalid_o !== 1'b0 || frame_avail_o !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_idle: got tvalid=%b avail=%b required 0 0",
                         name, m_tvalid_o, frame_avail_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_tready_o !== 1'b0 || m_tvalid_o !== 1'b0 || frame_avail_o !== 1'b0 ||
            frame_len_o !== 16'd0 || frames_rx_o !== 16'd0 || frames_drop_o !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b v=%b av=%b len=%0d rx=%0d drop=%0d required all 0",
                     s_tready_o, m_tvalid_o, frame_avail_o, frame_len_o, frames_rx_o, frames_drop_o);
        end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (s_tready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_reset: got %b required 1", s_tready_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        m_tready_i = 1'b1;
        send_frame(4, 4'h3, 1'b0, 1'b1, 0);
        n_checks++;
        if (m_tvalid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: got tvalid=%b required 0", m_tvalid_o);
        end
        n_checks++;
        if (frame_avail_o !== 1'b1 || frame_len_o !== 16'd14) begin
            n_errors++;
            $display("FAIL good_len: got avail=%b len=%0d required 1 14", frame_avail_o, frame_len_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_tvalid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL latency_2cyc: got tvalid=%b required 1", m_tvalid_o);
        end
        wait_drain("good");
        check_counters("good");
    endtask

    task automatic test_bad_frame();
        m_tready_i = 1'b1;
        send_frame(3, 4'hF, 1'b1, 1'b0, 0);
        check_idle_out("bad", 4);
        check_counters("bad");
        send_frame(2, 4'h1, 1'b0, 1'b1, 0);
        wait_drain("after_bad");
        check_counters("after_bad");
    endtask

    task automatic test_overflow();
        m_tready_i = 1'b0;
        send_frame(10, 4'hF, 1'b0, 1'b0, 0);
        check_idle_out("ovf", 3);
        check_counters("ovf");
        // A full-depth frame only fits if the dropped beats were released.
        send_frame(DEPTH, 4'h7, 1'b0, 1'b1, 0);
        @(posedge clk); #1;
        n_checks++;
        if (frame_avail_o !== 1'b1 || frame_len_o !== 16'(KW * (DEPTH - 1) + 3)) begin
            n_errors++;
            $display("FAIL ovf_refill: got avail=%b len=%0d required 1 %0d",
                     frame_avail_o, frame_len_o, KW * (DEPTH - 1) + 3);
        end
        m_tready_i = 1'b1;
        wait_drain("ovf_refill");
        check_counters("ovf_refill");
    endtask

    task automatic test_len_fifo_full();
        m_tready_i = 1'b0;
        send_frame(1, 4'h1, 1'b0, 1'b1, 0);
        send_frame(1, 4'h3, 1'b0, 1'b1, 0);
        send_frame(1, 4'hF, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (frame_avail_o !== 1'b1 || frame_len_o !== 16'd1) begin
            n_errors++;
            $display("FAIL fifo_full_head: got avail=%b len=%0d required 1 1", frame_avail_o, frame_len_o);
        end
        check_counters("fifo_full");
        m_tready_i = 1'b1;
        wait_drain("fifo_full");
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    int          nb;
                    logic [KW-1:0] lk;
                    bit          bad;
                    int          c;
                    nb  = $urandom_range(1, 4);
                    lk  = KW'($urandom_range(1, 15));
                    bad = ($urandom_range(99) < 15);
                    c   = 0;
                    while (len_q.size() >= 2 && c < 300) begin
                        @(posedge clk); #1;
                        c++;
                    end
                    if (c >= 300) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL random_throttle: got %0d frames pending required <2", len_q.size());
                    end
                    send_frame(nb, lk, bad, !bad, 30);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_tready_i = ($urandom_range(99) < 60);
                    @(posedge clk); #1;
                end
            end
        join
        m_tready_i = 1'b1;
        wait_drain("random");
        check_counters("random");
    endtask

    task automatic test_reset_mid_frame();
        m_tready_i = 1'b0;
        send_frame(1, 4'hF, 1'b0, 1'b1, 0);
        s_tdata_i  = 32'hDEAD_0001;
        s_tkeep_i  = 4'hF;
        s_tvalid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_tvalid_i = 1'b0;
        rst_i      = 1'b1;
        exp_q.delete();
        len_q.delete();
        exp_rx   = 0;
        exp_drop = 0;
        @(posedge clk); #1;
        n_checks++;
        if (s_tready_o !== 1'b0 || m_tvalid_o !== 1'b0 || frame_avail_o !== 1'b0 ||
            frame_len_o !== 16'd0 || frames_rx_o !== 16'd0 || frames_drop_o !== 16'd0) begin
            n_errors++;
            $display("FAIL midreset_state: got rdy=%b v=%b av=%b len=%0d rx=%0d drop=%0d required all 0",
                     s_tready_o, m_tvalid_o, frame_avail_o, frame_len_o, frames_rx_o, frames_drop_o);
        end
        rst_i      = 1'b0;
        m_tready_i = 1'b1;
        #1;
        send_frame(3, 4'hC, 1'b0, 1'b1, 0);
        wait_drain("post_reset");
        check_counters("post_reset");
    endtask

    initial begin
        rst_i      = 1'b1;
        s_tdata_i  = '0;
        s_tkeep_i  = '0;
        s_tlast_i  = 1'b0;
        s_tuser_i  = 1'b0;
        s_tvalid_i = 1'b0;
        m_tready_i = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_overflow();
        test_len_fifo_full();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
